// File: rtl/csi2tx_dphy_pkg.sv
// Shared definitions for the CSI-2 TX D-PHY programmable byte-clock divider:
// default parameters, FSM encoding and the ratio decode.
package csi2tx_dphy_pkg;

    localparam int SEL_W_DEF   = 2;
    localparam int MAX_SEL_DEF = 3;
    localparam int DEF_SEL_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } div_state_t;

    // Divide ratio N = 2^(sel+1).
    function automatic int unsigned div_ratio(input int unsigned sel);
        return 32'd2 << sel;
    endfunction

endpackage

// File: rtl/csi2tx_dphy_div_cnt.sv
// Phase counter for the byte-clock divider: counts 0..N-1 while running and
// flags the half-period, pre-boundary and boundary phases for the active ratio.
module csi2tx_dphy_div_cnt
    import csi2tx_dphy_pkg::*;
#(
    parameter int SEL_W   = SEL_W_DEF,
    parameter int MAX_SEL = MAX_SEL_DEF
) (
    input  logic             ddrclkhs,
    input  logic             rst,
    input  logic             run,
    input  logic [SEL_W-1:0] sel,
    output logic             last,
    output logic             pre_last,
    output logic             mid
);

    localparam int CNT_W = MAX_SEL + 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n_m1;
    logic [CNT_W-1:0] n_m2;
    logic [CNT_W-1:0] half_m1;

    always_comb begin
        n_m1    = CNT_W'(div_ratio(32'(sel)) - 32'd1);
        n_m2    = CNT_W'(div_ratio(32'(sel)) - 32'd2);
        half_m1 = CNT_W'((div_ratio(32'(sel)) >> 1) - 32'd1);
    end

    assign last     = (cnt == n_m1);
    assign pre_last = (cnt == n_m2);
    assign mid      = (cnt == half_m1);

    // NOTE: sequential state uses non-blocking assignment so every reader sees the pre-edge value.
    always_ff @(posedge ddrclkhs) begin
        if (rst || !run || last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/csi2tx_dphy_prog_clk_div.sv
// Programmable divider producing the lane byte clock from the HS DDR clock,
// with glitch-free start/stop and ratio changes only at period boundaries.
module csi2tx_dphy_prog_clk_div
    import csi2tx_dphy_pkg::*;
#(
    parameter int SEL_W   = SEL_W_DEF,
    parameter int MAX_SEL = MAX_SEL_DEF,
    parameter int DEF_SEL = DEF_SEL_DEF
) (
    input  logic             ddrclkhs,
    input  logic             rst,
    input  logic             clk_en,
    input  logic [SEL_W-1:0] div_sel,
    output logic             byteclkhs,
    output logic             load_strb,
    output logic             ready,
    output logic [SEL_W-1:0] active_sel
);

    localparam logic [SEL_W-1:0] MAX_SEL_L = SEL_W'(MAX_SEL);
    localparam logic [SEL_W-1:0] DEF_SEL_L = SEL_W'(DEF_SEL);

    div_state_t       state;
    logic [SEL_W-1:0] sel_clamped;
    logic             last;
    logic             pre_last;
    logic             mid;

    assign sel_clamped = (div_sel > MAX_SEL_L) ? MAX_SEL_L : div_sel;

    csi2tx_dphy_div_cnt #(
        .SEL_W   (SEL_W),
        .MAX_SEL (MAX_SEL)
    ) u_div_cnt (
        .ddrclkhs (ddrclkhs),
        .rst      (rst),
        .run      (state != ST_IDLE),
        .sel      (active_sel),
        .last     (last),
        .pre_last (pre_last),
        .mid      (mid)
    );

    // Outputs are loaded with the values the counter will have after this edge.
    always_ff @(posedge ddrclkhs) begin
        if (rst) begin
            state      <= ST_IDLE;
            byteclkhs  <= 1'b0;
            load_strb  <= 1'b0;
            ready      <= 1'b0;
            active_sel <= DEF_SEL_L;
        end else begin
            case (state)
                ST_IDLE: begin
                    active_sel <= sel_clamped;
                    load_strb  <= 1'b0;
                    ready      <= 1'b0;
                    if (clk_en) begin
                        state     <= ST_RUN;
                        byteclkhs <= 1'b1;
                    end else begin
                        byteclkhs <= 1'b0;
                    end
                end
                ST_RUN, ST_STOPPING: begin
                    if (last) begin
                        active_sel <= sel_clamped;
                        load_strb  <= 1'b0;
                        if (clk_en) begin
                            state     <= ST_RUN;
                            byteclkhs <= 1'b1;
                            ready     <= (sel_clamped == active_sel);
                        end else begin
                            state     <= ST_IDLE;
                            byteclkhs <= 1'b0;
                            ready     <= 1'b0;
                        end
                    end else begin
                        state     <= clk_en ? ST_RUN : ST_STOPPING;
                        load_strb <= pre_last;
                        if (mid) begin
                            byteclkhs <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    byteclkhs <= 1'b0;
                    load_strb <= 1'b0;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/csi2tx_dphy_prog_clk_div.md
CSI2TX_DPHY_PROG_CLK_DIV -- requirements
Module: csi2tx_dphy_prog_clk_div

Interface
REQ-001 SHALL have parameter SEL_W, default 2: width of div_sel.
REQ-002 SHALL have parameter MAX_SEL, default 3: largest legal ratio select; must be at most 2^SEL_W-1.
REQ-003 SHALL have parameter DEF_SEL, default 1: ratio select loaded at reset (divide-by-4, 8-bit lane byte clock).
REQ-004 SHALL have port ddrclkhs, input, 1: high-speed DDR clock; the only clock.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port clk_en, input, 1: request to run the divided clock.
REQ-007 SHALL have port div_sel, input, SEL_W: requested ratio; divide ratio N = 2^(div_sel+1).
REQ-008 SHALL have port byteclkhs, output, 1: registered divided clock, 50% duty.
REQ-009 SHALL have port load_strb, output, 1: one-cycle pulse on the last ddrclkhs cycle of each divided period.
REQ-010 SHALL have port ready, output, 1: divided clock running at a settled ratio.
REQ-011 SHALL have port active_sel, output, SEL_W: ratio select currently in effect.

Function
REQ-012 SHALL clamp any div_sel above MAX_SEL to MAX_SEL before use.
REQ-013 SHALL keep an internal phase counter cnt, width MAX_SEL+1, counting 0..N-1 and wrapping to 0 while running.
REQ-014 SHALL drive byteclkhs high when cnt is in 0..N/2-1 and low when cnt is in N/2..N-1, from a flop with no combinational output path.
REQ-015 SHALL implement FSM states IDLE, RUN and STOPPING.
REQ-016 IDLE: cnt held at 0, byteclkhs low; clk_en high moves to RUN, and the first RUN cycle has cnt=0 with byteclkhs high.
REQ-017 RUN: clk_en low moves to STOPPING; a period already in progress is never truncated.
REQ-018 STOPPING: the current period completes through cnt=N-1, then the FSM goes to IDLE with byteclkhs low.
REQ-019 STOPPING: if clk_en returns high before cnt=N-1, the FSM returns to RUN with no gap or glitch.
REQ-020 SHALL sample the clamped div_sel into active_sel only in IDLE or on the cycle where cnt=N-1; changes mid-period are ignored until that boundary.
REQ-021 SHALL assert load_strb exactly when state is RUN or STOPPING and cnt=N-1.
REQ-022 SHALL raise ready on the cycle after the first load_strb that follows entry to RUN or an active_sel change.
REQ-023 SHALL lower ready on entry to IDLE and on the boundary where active_sel changes value.
REQ-024 For N=2 (sel 0), byteclkhs SHALL toggle every cycle and load_strb SHALL be high on every low cycle.

Reset
REQ-025 While rst is high, SHALL force: state IDLE, cnt 0, byteclkhs 0, load_strb 0, ready 0, active_sel DEF_SEL.
REQ-026 rst asserted mid-period SHALL take effect at the next ddrclkhs edge, with no completion of the period.
REQ-027 After release, SHALL stay in IDLE until clk_en is sampled high.

Structure
REQ-028 SHALL place the state encodings, the default SEL_W/MAX_SEL/DEF_SEL values and the ratio-decode helper in a shared package, csi2tx_dphy_pkg.
REQ-029 SHALL be a single module; the period counter and boundary logic MAY be a sub-module, csi2tx_dphy_div_cnt.

Verification
REQ-030 Reset then clk_en=1, div_sel=1 -> byteclkhs pattern 1,1,0,0 repeating; load_strb on every 4th cycle; ready rises on cycle 5.
REQ-031 Running at sel=2, div_sel changed to 3 at cnt=2 -> remaining 8-cycle period unchanged; active_sel becomes 3 at the boundary; next period is 16 cycles; ready drops for one period, then recovers.
REQ-032 Running at sel=1, clk_en dropped at cnt=1 -> period completes (2 more cycles); then IDLE with byteclkhs 0 and ready 0; clk_en dropped then re-raised at cnt=2 -> continuous clock with no gap.
REQ-033 div_sel=3 with MAX_SEL=2 -> active_sel=2, period of 8 cycles.
REQ-034 rst pulsed for 1 cycle at cnt=1 while byteclkhs is high -> byteclkhs=0, ready=0, active_sel=DEF_SEL on the next edge; restart begins at cnt=0.
REQ-035 sel=0 -> byteclkhs alternates 1,0; load_strb high on every low cycle; checker confirms no high or low phase shorter than N/2 across all transitions.
